// File: rtl/apb_timer_arbiter.sv
// Two-master round-robin APB arbiter in front of the shared timer slave.
// Each grant is re-issued downstream with fresh SETUP/ACCESS phases and guarded by an access timeout.
`timescale 1ns/1ps

module apb_timer_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resp_vld,
  input  logic              cap_data,
  input  logic [DATA_W-1:0] rdata,
  input  logic              err,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  // prdata persists across writes; pready/pslverr are single-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      pready  <= resp_vld;
      pslverr <= resp_vld & err;
      if (resp_vld && cap_data) prdata <= rdata;
    end
  end
endmodule

module apb_timer_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic              s_psel,
  output logic              s_penable,
  output logic              s_pwrite,
  output logic [ADDR_W-1:0] s_paddr,
  output logic [DATA_W-1:0] s_pwdata,
  input  logic [DATA_W-1:0] s_prdata,
  input  logic              s_pready,
  input  logic              s_pslverr
);
  localparam int NM    = 2;
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  logic [NM-1:0]             m_psel, m_pwrite, m_pready, m_pslverr;
  logic [NM-1:0][ADDR_W-1:0] m_paddr;
  logic [NM-1:0][DATA_W-1:0] m_pwdata, m_prdata;

  assign m_psel   = {m1_psel, m0_psel};
  assign m_pwrite = {m1_pwrite, m0_pwrite};
  assign m_paddr  = {m1_paddr, m0_paddr};
  assign m_pwdata = {m1_pwdata, m0_pwdata};

  assign {m1_prdata,  m0_prdata}  = m_prdata;
  assign {m1_pready,  m0_pready}  = m_pready;
  assign {m1_pslverr, m0_pslverr} = m_pslverr;

  // penable carries no information the arbiter needs: pending means psel
  logic unused_penable;
  assign unused_penable = &{1'b0, m0_penable, m1_penable};

  state_t           state;
  logic             gnt, last_grant, dropped;
  logic [CNT_W-1:0] cnt;
  logic             pick, any_req, gnt_psel, to_hit, done, abandon, keep;

  always_comb begin
    any_req  = |m_psel;
    pick     = (&m_psel) ? ~last_grant : m_psel[1];
    gnt_psel = m_psel[gnt];
    to_hit   = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    done     = (state == ACCESS) && (s_pready || to_hit);
    abandon  = done && !s_pready;
    keep     = gnt_psel && !dropped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      dropped    <= 1'b0;
      cnt        <= '0;
      s_psel     <= 1'b0;
      s_penable  <= 1'b0;
      s_pwrite   <= 1'b0;
      s_paddr    <= '0;
      s_pwdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            gnt        <= pick;
            last_grant <= pick;
            dropped    <= 1'b0;
            s_pwrite   <= m_pwrite[pick];
            s_paddr    <= m_paddr[pick];
            s_pwdata   <= m_pwdata[pick];
            s_psel     <= 1'b1;
            s_penable  <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          cnt       <= '0;
          s_penable <= 1'b1;
          if (!gnt_psel) dropped <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // saturates so a disabled or very long timeout never wraps
          if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + CNT_W'(1);
          if (!gnt_psel) dropped <= 1'b1;
          if (done) begin
            s_psel    <= 1'b0;
            s_penable <= 1'b0;
            state     <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a master that abandoned its request gets no response strobe
  for (genvar i = 0; i < NM; i++) begin : g_port
    apb_timer_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .clk      (clk),
      .rst      (rst),
      .resp_vld (done && keep && (gnt == 1'(i))),
      .cap_data (abandon || !s_pwrite),
      .rdata    (abandon ? '0 : s_prdata),
      .err      (abandon || s_pslverr),
      .prdata   (m_prdata[i]),
      .pready   (m_pready[i]),
      .pslverr  (m_pslverr[i])
    );
  end
endmodule
